dm_ctrl: RTL and testbench

- Data-memory responder on the accumulator's byte-wide memory port.
- Services write requests (dm_wr with dm_in) and read requests (dm_r, data returned on dm_out) against an internal byte array.
- The byte array is addressed by a local address register, loaded or incremented by the control unit.
- Sits between the accumulator and the pixel/sample store of the downsampling datapath.

---
 rtl/dm_ctrl.sv | 83 ++++++++
 tb/tb_dm_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dm_ctrl.sv
// dm_ctrl: byte-wide data-memory responder with local address register.
// Optional DM_AUTOINC_EN: advance the address after each committed write or completed read.
module dm_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              dm_wr,
    input  logic              dm_r,
    input  logic [7:0]        dm_in,
    input  logic              ar_load,
    input  logic [ADDR_W-1:0] ar_in,
    input  logic              ar_inc,
    output logic [7:0]        dm_out,
    output logic              dm_rdy,
    output logic              wr_ack,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] ar_out
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RD   = 1'b1;

    logic [7:0]        r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ar;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_dm_out;
    logic              r_dm_rdy;
    logic              r_wr_ack;
    logic              r_err;
    logic              w_idle;
    logic              w_wr_commit;
    logic              w_rd_start;
    logic              w_rd_done;
    logic              w_drop;
    logic              w_inc;

    assign w_idle      = r_state == S_IDLE;
    assign w_wr_commit = w_idle && dm_wr;
    assign w_rd_start  = w_idle && dm_r && !dm_wr;
    assign w_rd_done   = r_state == S_RD;
    assign w_drop      = (w_idle && dm_wr && dm_r) || (w_rd_done && (dm_wr || dm_r));
`ifdef DM_AUTOINC_EN
    // Auto and explicit increments collapse into a single +1.
    assign w_inc = ar_inc || w_wr_commit || w_rd_done;
`else
    assign w_inc = ar_inc;
`endif

    // Array has no reset so its contents survive rst.
    always_ff @(posedge clock)
        if (!rst && w_wr_commit)
            r_mem[r_ar] <= dm_in;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ar     <= '0;
            r_raddr  <= '0;
            r_dm_out <= '0;
            r_dm_rdy <= 1'b0;
            r_wr_ack <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_rd_start ? S_RD : S_IDLE;
            r_ar     <= ar_load ? ar_in : w_inc ? r_ar + ADDR_W'(1) : r_ar;
            r_raddr  <= w_rd_start ? r_ar : r_raddr;
            r_dm_out <= w_rd_done ? r_mem[r_raddr] : r_dm_out;
            r_dm_rdy <= w_rd_done;
            r_wr_ack <= w_wr_commit;
            r_err    <= r_err || w_drop;
        end
    end

    assign dm_out = r_dm_out;
    assign dm_rdy = r_dm_rdy;
    assign wr_ack = r_wr_ack;
    assign busy   = r_state == S_RD;
    assign err    = r_err;
    assign ar_out = r_ar;
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed self-checking bench for dm_ctrl.
// Define DM_AUTOINC_EN for both files to exercise the auto-increment build.
module tb_dm_ctrl;
    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        dm_wr = 1'b0;
    logic        dm_r = 1'b0;
    logic [7:0]  dm_in = '0;
    logic        ar_load = 1'b0;
    logic [11:0] ar_in = '0;
    logic        ar_inc = 1'b0;
    logic [7:0]  dm_out;
    logic        dm_rdy;
    logic        wr_ack;
    logic        busy;
    logic        err;
    logic [11:0] ar_out;
    int          total = 0;
    int          bad = 0;

    dm_ctrl #(.ADDR_W(12), .DEPTH(4096)) dut (
        .clock(clock), .rst(rst), .dm_wr(dm_wr), .dm_r(dm_r), .dm_in(dm_in),
        .ar_load(ar_load), .ar_in(ar_in), .ar_inc(ar_inc), .dm_out(dm_out),
        .dm_rdy(dm_rdy), .wr_ack(wr_ack), .busy(busy), .err(err), .ar_out(ar_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [11:0] a);
        ar_load = 1'b1; ar_in = a;
        tick();
        ar_load = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        load(a);
        dm_wr = 1'b1; dm_in = d;
        tick();
        dm_wr = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] exp);
        load(a);
        dm_r = 1'b1;
        tick();
        dm_r = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        tick();
        chk({tag, "_rdy"}, dm_rdy, 1);
        chk({tag, "_data"}, dm_out, exp);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ar", ar_out, 0);
        chk("rst_out", dm_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_rdy", dm_rdy, 0);
        chk("rst_ack", wr_ack, 0);

        load(12'h010);
        chk("load_ar", ar_out, 12'h010);
        dm_wr = 1'b1; dm_in = 8'hA5;
        tick();
        dm_wr = 1'b0;
        chk("wr_ack", wr_ack, 1);
        chk("wr_nobusy", busy, 0);
        tick();
        chk("wr_ack_pulse", wr_ack, 0);
        rd_chk("rd010", 12'h010, 8'hA5);
        chk("rd010_busy_clr", busy, 0);
        tick();
        chk("rd010_rdy_pulse", dm_rdy, 0);
        chk("rd010_hold", dm_out, 8'hA5);

        load(12'hFFF);
        ar_inc = 1'b1;
        tick();
        ar_inc = 1'b0;
        chk("ar_wrap", ar_out, 12'h000);
        ar_load = 1'b1; ar_in = 12'h123; ar_inc = 1'b1;
        tick();
        ar_load = 1'b0;
        chk("ar_load_prio", ar_out, 12'h123);
        tick();
        ar_inc = 1'b0;
        chk("ar_inc", ar_out, 12'h124);

        wr(12'h020, 8'h77);
        load(12'h020);
        dm_r = 1'b1;
        tick();
        dm_r = 1'b0;
        dm_wr = 1'b1; dm_in = 8'h5A;
        tick();
        dm_wr = 1'b0;
        chk("rdcol_ack", wr_ack, 0);
        chk("rdcol_rdy", dm_rdy, 1);
        chk("rdcol_data", dm_out, 8'h77);
        chk("rdcol_err", err, 1);
        rd_chk("rd020", 12'h020, 8'h77);
        chk("err_sticky", err, 1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_err", err, 0);
        chk("rst2_out", dm_out, 0);
        load(12'h030);
        dm_wr = 1'b1; dm_r = 1'b1; dm_in = 8'h3C;
        tick();
        dm_wr = 1'b0; dm_r = 1'b0;
        chk("both_ack", wr_ack, 1);
        chk("both_busy", busy, 0);
        chk("both_err", err, 1);
        tick();
        chk("both_nordy", dm_rdy, 0);
        rd_chk("rd030", 12'h030, 8'h3C);

        load(12'h010);
        dm_r = 1'b1;
        tick();
        dm_r = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstrd_rdy", dm_rdy, 0);
        chk("rstrd_out", dm_out, 0);
        chk("rstrd_busy", busy, 0);
        chk("rstrd_ar", ar_out, 0);
        tick();
        chk("rstrd_rdy2", dm_rdy, 0);
        rd_chk("rd010b", 12'h010, 8'hA5);

`ifdef DM_AUTOINC_EN
        load(12'h0FE);
        dm_wr = 1'b1;
        dm_in = 8'h11; tick();
        dm_in = 8'h22; tick();
        dm_in = 8'h33; tick();
        dm_wr = 1'b0;
        chk("ai_wr_ar", ar_out, 12'h101);
        load(12'h0FE);
        dm_r = 1'b1; tick(); dm_r = 1'b0; tick();
        chk("ai_rd0", dm_out, 8'h11);
        chk("ai_rd0_ar", ar_out, 12'h0FF);
        dm_r = 1'b1; tick(); dm_r = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("ai_rst_rdy", dm_rdy, 0);
        chk("ai_rst_out", dm_out, 0);
        chk("ai_rst_ar", ar_out, 0);
        load(12'h0FF);
        dm_r = 1'b1; tick(); dm_r = 1'b0; tick();
        chk("ai_rd1", dm_out, 8'h22);
        dm_r = 1'b1; tick(); dm_r = 1'b0; tick();
        chk("ai_rd2", dm_out, 8'h33);
        chk("ai_rd2_ar", ar_out, 12'h101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
